line_buf_scanout: RTL and testbench
===================================

Name: line_buf_scanout

Overview:
- Downstream consumer of the 32-bit-write / 8-bit-read line buffer, on the read-clock side.
- On each line_start, reads a run of LINE_PIX 4bpp pixels out of the 1024-byte buffer. Each byte holds two pixels; the run starts at a fine-scroll pixel offset, with optional horizontal flip.
- Compensates for the buffer's 2-cycle registered read latency and delivers one palette-indexed pixel per clock to the priority mixer.

Parameters:
- LINE_PIX, 256, pixels emitted per line (1..2048).
- PIPE_LAT, 2, read latency of the line buffer in clocks. The design supports only 2; any other value is a synthesis-time error.

Ports:
- clk  in  1  pixel clock, also drives the buffer rdclock.
- rst_n  in  1  asynchronous active-low reset.
- line_start  in  1  single-cycle pulse that starts or restarts a line.
- start_pix  in  11  starting pixel index in the buffer, sampled on line_start.
- flip  in  1  1 = pointer decrements, sampled on line_start.
- pal_bank  in  4  palette bank, sampled on line_start.
- rd_en  out  1  buffer read enable (to rden).
- rd_addr  out  10  buffer byte address (to rdaddress).
- rd_data  in  8  buffer read data (from q).
- pix_out  out  8  {bank, nibble}.
- pix_vld  out  1  pix_out valid.
- pix_opq  out  1  nibble != 0, qualified by pix_vld.
- pix_last  out  1  marks the final pixel of the line.
- busy  out  1  high from line_start until the last pixel has been emitted.

Behaviour:
- Reset:
  - state = IDLE; rd_en, rd_addr, pix_out, pix_vld, pix_opq, pix_last and busy all 0.
  - All pipeline tags are cleared. Reset is honoured mid-line, and outputs drop to 0 immediately.
- States are IDLE, RUN and DRAIN.
- IDLE -> RUN on line_start:
  - Latch ptr = start_pix, dir = flip, bank = pal_bank.
  - Load cnt = LINE_PIX; busy goes to 1 on the next cycle.
- RUN, each cycle:
  - rd_en = 1 and rd_addr = ptr[10:1].
  - Push tag {nsel = ptr[0], last = (cnt == 1)} into a 2-deep valid-qualified shift register.
  - ptr = ptr + 1 (dir = 0) or ptr - 1 (dir = 1), modulo 2048. So 2047 -> 0 when incrementing and 0 -> 2047 when decrementing.
  - cnt decrements. When cnt == 1 is issued, go to DRAIN.
- Nibble order: nsel = 0 selects rd_data[3:0]; nsel = 1 selects rd_data[7:4]. This holds independent of flip.
- Pipeline timing:
  - A read issued in cycle N has rd_data valid in cycle N+2.
  - pix_out, pix_vld, pix_opq and pix_last are registered at the end of N+2 and therefore visible in cycle N+3.
  - Issue-to-pixel latency is 3 clocks.
- pix_vld is high for exactly LINE_PIX consecutive cycles, with no bubbles.
- pix_last is high only together with the final pix_vld.
- DRAIN:
  - rd_en = 0.
  - Remain in DRAIN until the last tag has produced its pixel, then go to IDLE.
  - busy falls in the cycle after pix_last.
- Outside valid cycles, pix_out and pix_opq hold 0.
- line_start during RUN or DRAIN:
  - Abort and flush all in-flight tags; no stale pixel may be emitted.
  - Relatch the inputs and re-enter RUN on the next cycle. busy stays 1.
  - pix_vld is 0 for the 3 cycles before the new line's first pixel.
- line_start coincident with the final pixel of the old line: the restart wins. pix_last is suppressed if that pixel had not yet been registered.
- rd_en is 0 whenever the state is not RUN.

Test Plan:
- Basic run:
  - Stimulus: buffer byte k = k[7:0]; line_start with start_pix = 0, flip = 0, pal_bank = 5, LINE_PIX = 8.
  - Required: rd_addr sequence 0,0,1,1,2,2,3,3; first pix_vld 3 cycles after the first rd_en.
  - Required: pix_out = 0x50,0x50,0x51,0x50,0x52,0x50,0x53,0x50; pix_opq = 0,0,1,0,1,0,1,0; pix_last on the 8th pixel.
- Odd start with flip:
  - Stimulus: start_pix = 5, flip = 1, LINE_PIX = 4.
  - Required: rd_addr sequence 2,2,1,1; nibble selects hi,lo,hi,lo.
- Wrap-around:
  - Stimulus: start_pix = 2046, flip = 0, LINE_PIX = 4. Then start_pix = 1, flip = 1, LINE_PIX = 4.
  - Required (first line): rd_addr sequence 1023,1023,0,0.
  - Required (second line): rd_addr sequence 0,0,1023,1023.
- Mid-line restart:
  - Stimulus: line_start again after 3 RUN cycles of a 16-pixel line.
  - Required: at most 0 stale pixels from the old line after the restart is processed.
  - Required: a gap of exactly 3 invalid cycles, then 16 valid pixels of the new line, a single pix_last, and busy continuous.
- Reset mid-line:
  - Stimulus: assert rst_n = 0 asynchronously during RUN.
  - Required: all outputs 0 with no clock edge needed; after release, IDLE with no spurious pix_vld until the next line_start.
- Back-to-back lines:
  - Stimulus: line_start in the cycle after pix_last.
  - Required: the second line's pixels are exact and busy re-rises.
  - Required: total pix_vld count = 2 × LINE_PIX.

Source files
------------

// File: rtl/line_buf_scanout.sv
// Scan-out side of the 4bpp line buffer: walks LINE_PIX pixels from a fine-scroll
// offset (optionally backwards) and emits one {bank, nibble} pixel per clock.
module line_buf_scanout #(
    parameter int LINE_PIX = 256,
    parameter int PIPE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [10:0] start_pix,
    input  logic        flip,
    input  logic [3:0]  pal_bank,
    output logic        rd_en,
    output logic [9:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic [7:0]  pix_out,
    output logic        pix_vld,
    output logic        pix_opq,
    output logic        pix_last,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    generate
        if (PIPE_LAT != 2) begin : g_bad_lat
            $error("line_buf_scanout: only PIPE_LAT == 2 is supported");
        end
        if (LINE_PIX < 1 || LINE_PIX > 2048) begin : g_bad_len
            $error("line_buf_scanout: LINE_PIX must be 1..2048");
        end
    endgenerate

    localparam logic [11:0] CNT_INIT = 12'(LINE_PIX);

    state_t      state_q, state_d;
    logic [10:0] ptr_q, ptr_d;
    logic        dir_q, dir_d;
    logic [3:0]  bank_q, bank_d;
    logic [11:0] cnt_q, cnt_d;
    logic        issue;

    // Tag pipeline: t1 = read issued last cycle, t2 = read whose data is on rd_data now.
    logic        t1_vld_q, t1_nsel_q, t1_last_q;
    logic        t2_vld_q, t2_nsel_q, t2_last_q;

    logic        rd_en_q;
    logic [9:0]  rd_addr_q;
    logic [7:0]  pix_out_q;
    logic        pix_vld_q, pix_opq_q, pix_last_q, busy_q;

    logic [3:0]  nib;
    logic        emit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        if (line_start) begin
            // A restart from any state relatches and discards everything in flight.
            state_d = RUN;
            ptr_d   = start_pix;
            dir_d   = flip;
            bank_d  = pal_bank;
            cnt_d   = CNT_INIT;
        end else begin
            case (state_q)
                RUN: begin
                    issue = 1'b1;
                    ptr_d = dir_q ? (ptr_q - 11'd1) : (ptr_q + 11'd1);
                    cnt_d = cnt_q - 12'd1;
                    if (cnt_q == 12'd1) state_d = DRAIN;
                end
                DRAIN: begin
                    if (pix_last_q) state_d = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    assign nib  = t2_nsel_q ? rd_data[7:4] : rd_data[3:0];
    assign emit = t2_vld_q & ~line_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 11'd0;
            dir_q      <= 1'b0;
            bank_q     <= 4'd0;
            cnt_q      <= 12'd0;
            t1_vld_q   <= 1'b0;
            t1_nsel_q  <= 1'b0;
            t1_last_q  <= 1'b0;
            t2_vld_q   <= 1'b0;
            t2_nsel_q  <= 1'b0;
            t2_last_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= 10'd0;
            pix_out_q  <= 8'd0;
            pix_vld_q  <= 1'b0;
            pix_opq_q  <= 1'b0;
            pix_last_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            dir_q      <= dir_d;
            bank_q     <= bank_d;
            cnt_q      <= cnt_d;
            t1_vld_q   <= issue;
            t1_nsel_q  <= ptr_q[0];
            t1_last_q  <= (cnt_q == 12'd1);
            t2_vld_q   <= t1_vld_q & ~line_start;
            t2_nsel_q  <= t1_nsel_q;
            t2_last_q  <= t1_last_q;
            rd_en_q    <= (state_d == RUN);
            rd_addr_q  <= (state_d == RUN) ? ptr_d[10:1] : 10'd0;
            busy_q     <= (state_d != IDLE);
            pix_vld_q  <= emit;
            pix_out_q  <= emit ? {bank_q, nib} : 8'd0;
            pix_opq_q  <= emit & (nib != 4'd0);
            pix_last_q <= emit & t2_last_q;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign pix_out   = pix_out_q;
    assign pix_vld   = pix_vld_q;
    assign pix_opq   = pix_opq_q;
    assign pix_last  = pix_last_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_line_buf_scanout.sv
// Bench for line_buf_scanout: three instances (LINE_PIX 8/4/16), each fed by a
// 2-clock registered buffer model whose byte k holds k[7:0].
module tb_line_buf_scanout;

    logic        clk;
    logic        rst_n;
    logic        ls [3];
    logic [10:0] sp;
    logic        fl;
    logic [3:0]  pb;

    logic        rd_en_w   [3];
    logic [9:0]  rd_addr_w [3];
    logic [7:0]  rd_data_w [3];
    logic [7:0]  pix_out_w [3];
    logic        pix_vld_w [3];
    logic        pix_opq_w [3];
    logic        pix_last_w[3];
    logic        busy_w    [3];
    logic [1:0]  st_w      [3];
    logic [9:0]  a1        [3];

    int total = 0;
    int bad   = 0;
    int mon_sel = 0;

    logic [9:0] addr_log[$];
    logic [9:0] pix_log[$];
    logic [1:0] trace_log[$];
    logic [9:0] exp_addr_q[$];
    logic [9:0] exp_pix_q[$];

    typedef struct packed {
        logic        ls;
        logic [10:0] sp;
        logic        fl;
        logic [3:0]  pb;
        logic [22:0] exp;
    } vec_t;
    vec_t vecs[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- DUTs ----------------
    line_buf_scanout #(.LINE_PIX(8), .PIPE_LAT(2)) u_lp8 (
        .clk(clk), .rst_n(rst_n), .line_start(ls[0]), .start_pix(sp), .flip(fl),
        .pal_bank(pb), .rd_en(rd_en_w[0]), .rd_addr(rd_addr_w[0]), .rd_data(rd_data_w[0]),
        .pix_out(pix_out_w[0]), .pix_vld(pix_vld_w[0]), .pix_opq(pix_opq_w[0]),
        .pix_last(pix_last_w[0]), .busy(busy_w[0]), .dbg_state(st_w[0]));

    line_buf_scanout #(.LINE_PIX(4), .PIPE_LAT(2)) u_lp4 (
        .clk(clk), .rst_n(rst_n), .line_start(ls[1]), .start_pix(sp), .flip(fl),
        .pal_bank(pb), .rd_en(rd_en_w[1]), .rd_addr(rd_addr_w[1]), .rd_data(rd_data_w[1]),
        .pix_out(pix_out_w[1]), .pix_vld(pix_vld_w[1]), .pix_opq(pix_opq_w[1]),
        .pix_last(pix_last_w[1]), .busy(busy_w[1]), .dbg_state(st_w[1]));

    line_buf_scanout #(.LINE_PIX(16), .PIPE_LAT(2)) u_lp16 (
        .clk(clk), .rst_n(rst_n), .line_start(ls[2]), .start_pix(sp), .flip(fl),
        .pal_bank(pb), .rd_en(rd_en_w[2]), .rd_addr(rd_addr_w[2]), .rd_data(rd_data_w[2]),
        .pix_out(pix_out_w[2]), .pix_vld(pix_vld_w[2]), .pix_opq(pix_opq_w[2]),
        .pix_last(pix_last_w[2]), .busy(busy_w[2]), .dbg_state(st_w[2]));

    // Line buffer: address registered, then data registered; byte k holds k[7:0].
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            a1[k]        <= rd_addr_w[k];
            rd_data_w[k] <= a1[k][7:0];
        end
    end

    // Monitor samples 1 ns after the active edge.
    always @(posedge clk) begin
        #1;
        if (rd_en_w[mon_sel])  addr_log.push_back(rd_addr_w[mon_sel]);
        if (pix_vld_w[mon_sel])
            pix_log.push_back({pix_last_w[mon_sel], pix_opq_w[mon_sel], pix_out_w[mon_sel]});
        trace_log.push_back({busy_w[mon_sel], pix_vld_w[mon_sel]});
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] outs(input int k);
        return {rd_en_w[k], rd_addr_w[k], pix_vld_w[k], pix_out_w[k],
                pix_opq_w[k], pix_last_w[k], busy_w[k]};
    endfunction

    function automatic vec_t mk(input logic l, input logic [10:0] s, input logic f,
                                input logic [3:0] b, input logic en, input logic [9:0] ad,
                                input logic v, input logic [7:0] o, input logic op,
                                input logic la, input logic bs);
        vec_t r;
        r.ls = l; r.sp = s; r.fl = f; r.pb = b;
        r.exp = {en, ad, v, o, op, la, bs};
        return r;
    endfunction

    function automatic logic [9:0] pk(input logic la, input logic op, input logic [7:0] o);
        return {la, op, o};
    endfunction

    // Expected pixel for buffer pixel index p: byte p>>1 holds (p>>1)[7:0].
    function automatic logic [9:0] px(input logic [10:0] p, input logic [3:0] b, input logic la);
        logic [7:0] byt;
        logic [3:0] n;
        byt = p[8:1];
        n   = p[0] ? byt[7:4] : byt[3:0];
        return {la, (n != 4'd0), b, n};
    endfunction

    task automatic clr_logs();
        addr_log.delete();
        pix_log.delete();
        trace_log.delete();
        exp_addr_q.delete();
        exp_pix_q.delete();
    endtask

    task automatic pulse(input int k, input logic [10:0] s, input logic f, input logic [3:0] b);
        sp = s; fl = f; pb = b;
        ls[k] = 1'b1;
        @(negedge clk);
        ls[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input string name);
        int n;
        n = 0;
        while (busy_w[k] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy still %0b after %0d cycles", name, busy_w[k], n);
        end
    endtask

    task automatic cmp_logs(input string name);
        chk({name, "_nrd"}, addr_log.size(), exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size() && i < addr_log.size(); i++)
            chk($sformatf("%s_rd%0d", name, i), 32'(addr_log[i]), 32'(exp_addr_q[i]));
        chk({name, "_npix"}, pix_log.size(), exp_pix_q.size());
        for (int i = 0; i < exp_pix_q.size() && i < pix_log.size(); i++)
            chk($sformatf("%s_pix%0d", name, i), 32'(pix_log[i]), 32'(exp_pix_q[i]));
    endtask

    // ---------------- test ----------------
    initial begin
        int n;
        int cnt;
        logic [1:0] e;

        rst_n = 1'b0;
        sp = '0; fl = 1'b0; pb = '0;
        for (int k = 0; k < 3; k++) ls[k] = 1'b0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_outs%0d", k), {7'd0, st_w[k], outs(k)}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run, LINE_PIX=8: one vector per cycle, cycle 0 carries line_start.
        //            ls sp fl pb   en addr vld out    opq last busy
        vecs.push_back(mk(1, 0, 0, 5,  0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5,  1, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  1, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  1, 1, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  1, 1, 1, 8'h50, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  1, 2, 1, 8'h50, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  1, 2, 1, 8'h51, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  1, 3, 1, 8'h50, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  1, 3, 1, 8'h52, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  0, 0, 1, 8'h50, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  0, 0, 1, 8'h53, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5,  0, 0, 1, 8'h50, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 5,  0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5,  0, 0, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            chk($sformatf("basic_c%0d", i), 32'(outs(0)), 32'(vecs[i].exp));
            ls[0] = vecs[i].ls; sp = vecs[i].sp; fl = vecs[i].fl; pb = vecs[i].pb;
            @(negedge clk);
        end
        ls[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Odd start, flipped, LINE_PIX=4.
        mon_sel = 1;
        clr_logs();
        exp_addr_q = '{10'd2, 10'd2, 10'd1, 10'd1};
        exp_pix_q  = '{pk(0, 0, 8'hA0), pk(0, 1, 8'hA2), pk(0, 0, 8'hA0), pk(1, 1, 8'hA1)};
        pulse(1, 11'd5, 1'b1, 4'hA);
        wait_done(1, "flip");
        cmp_logs("flip");
        repeat (2) @(negedge clk);

        // Wrap-around forward across 2047 -> 0.
        clr_logs();
        exp_addr_q = '{10'd1023, 10'd1023, 10'd0, 10'd0};
        exp_pix_q  = '{pk(0, 1, 8'h3F), pk(0, 1, 8'h3F), pk(0, 0, 8'h30), pk(1, 0, 8'h30)};
        pulse(1, 11'd2046, 1'b0, 4'h3);
        wait_done(1, "wrap_fwd");
        cmp_logs("wrap_fwd");
        repeat (2) @(negedge clk);

        // Wrap-around backward across 0 -> 2047.
        clr_logs();
        exp_addr_q = '{10'd0, 10'd0, 10'd1023, 10'd1023};
        exp_pix_q  = '{pk(0, 0, 8'h30), pk(0, 0, 8'h30), pk(0, 1, 8'h3F), pk(1, 1, 8'h3F)};
        pulse(1, 11'd1, 1'b1, 4'h3);
        wait_done(1, "wrap_bwd");
        cmp_logs("wrap_bwd");
        repeat (2) @(negedge clk);

        // Mid-line restart on the 16-pixel instance after 3 RUN cycles.
        mon_sel = 2;
        clr_logs();
        exp_addr_q = '{10'd0, 10'd0, 10'd1, 10'd1};
        for (int i = 0; i < 16; i++) exp_addr_q.push_back(10'(50 + i / 2));
        exp_pix_q.push_back(pk(0, 0, 8'h10));
        for (int i = 0; i < 16; i++) exp_pix_q.push_back(px(11'(100 + i), 4'h2, i == 15));
        pulse(2, 11'd0, 1'b0, 4'h1);
        repeat (3) @(negedge clk);
        pulse(2, 11'd100, 1'b0, 4'h2);
        wait_done(2, "restart");
        repeat (3) @(negedge clk);
        cmp_logs("restart");
        chk("restart_trace_len", 32'(trace_log.size() >= 26), 32'd1);
        for (int i = 0; i < 26 && i < trace_log.size(); i++) begin
            if (i <= 2)       e = 2'b10;
            else if (i == 3)  e = 2'b11;
            else if (i <= 6)  e = 2'b10;
            else if (i <= 22) e = 2'b11;
            else              e = 2'b00;
            chk($sformatf("restart_busy_vld%0d", i), 32'(trace_log[i]), 32'(e));
        end
        repeat (2) @(negedge clk);

        // Back-to-back lines: second line_start in the cycle after pix_last.
        mon_sel = 0;
        clr_logs();
        exp_addr_q = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd2, 10'd2, 10'd3, 10'd3,
                       10'd8, 10'd7, 10'd7, 10'd6, 10'd6, 10'd5, 10'd5, 10'd4};
        exp_pix_q  = '{pk(0, 0, 8'h50), pk(0, 0, 8'h50), pk(0, 1, 8'h51), pk(0, 0, 8'h50),
                       pk(0, 1, 8'h52), pk(0, 0, 8'h50), pk(0, 1, 8'h53), pk(1, 0, 8'h50),
                       pk(0, 1, 8'h78), pk(0, 0, 8'h70), pk(0, 1, 8'h77), pk(0, 0, 8'h70),
                       pk(0, 1, 8'h76), pk(0, 0, 8'h70), pk(0, 1, 8'h75), pk(1, 0, 8'h70)};
        pulse(0, 11'd0, 1'b0, 4'h5);
        n = 0;
        while (pix_last_w[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL b2b_last_timeout: no pix_last within %0d cycles", n);
        end
        @(negedge clk);
        chk("b2b_busy_gap", 32'(busy_w[0]), 32'd0);
        pulse(0, 11'd16, 1'b1, 4'h7);
        chk("b2b_busy_rise", 32'(busy_w[0]), 32'd1);
        wait_done(0, "b2b");
        repeat (2) @(negedge clk);
        cmp_logs("b2b");

        // Asynchronous reset during RUN.
        pulse(0, 11'd0, 1'b0, 4'h5);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {7'd0, st_w[0], outs(0)}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clr_logs();
        repeat (10) @(negedge clk);
        chk("post_reset_nrd", addr_log.size(), 32'd0);
        chk("post_reset_npix", pix_log.size(), 32'd0);
        cnt = 0;
        foreach (trace_log[i]) if (trace_log[i] != 2'b00) cnt++;
        chk("post_reset_busy_vld", cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
